dual_issue_scheduler: RTL and testbench
=======================================

Name: dual_issue_scheduler

Overview:
- Sits between the instruction window cache and the execute stage.
- Inspects the two head instructions, instruction0 and instruction1.
- Drives freeze1, freeze2 and dependency_on_ins2 back to the cache, which decide whether the window holds, slides by 1 or slides by 2.
- Registers the issued instruction pair to execute, and keeps a load-latency scoreboard and performance counters.

Parameters:
- LOAD_LATENCY, 2: cycles a load destination stays busy after issue (range 1..7).
- CNT_W, 32: width of the performance counters.

Ports:
- clk  input  1  system clock
- n_rst  input  1  asynchronous active-low reset
- nothing_filled  input  1  window empty; instruction0/1 are invalid
- instruction0  input  32  window head (slot0); 0 means empty
- instruction1  input  32  window head+1 (slot1); 0 means empty
- dmem_busy  input  1  data memory cannot accept a load/store this cycle
- freeze1  output  1  hold window; nothing issues
- freeze2  output  1  hold caused by dmem_busy (subset of freeze1)
- dependency_on_ins2  output  1  issue slot0 only; window slides by 1
- issue0_valid  output  1  registered: issue0_instr is valid
- issue0_instr  output  32  registered slot0 instruction
- issue1_valid  output  1  registered: issue1_instr is valid
- issue1_instr  output  32  registered slot1 instruction
- issue_count  output  CNT_W  instructions issued since reset
- stall_count  output  CNT_W  cycles with freeze1=1 and window non-empty

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-low, on n_rst; all flops clear on negedge n_rst.
- Reset values: all outputs 0; scoreboard cleared; FSM in EMPTY.

Decode (RV32I opcode = instr[6:0]):
- rs1 used by LOAD 0000011, STORE 0100011, BRANCH 1100011, JALR 1100111, OP-IMM 0010011, OP 0110011.
- rs2 used by STORE, BRANCH, OP.
- rd written by all valid opcodes except STORE and BRANCH. rd = x0 never writes and is never a hazard.
- mem-op = LOAD or STORE. ctrl = BRANCH, JAL 1101111 or JALR.
- Unknown opcodes: treated as no sources, no rd, issue normally.

Scoreboard:
- 32 entries, each a 3-bit down-counter.
- An issued LOAD with rd != 0 loads cnt[rd] = LOAD_LATENCY at the clock edge.
- Every other nonzero entry decrements by 1 per cycle.
- Set wins over decrement on the same entry in the same cycle.
- busy(r) = (cnt[r] != 0).

Combinational stall decision (same cycle as the inputs):
- v0 = !nothing_filled && instruction0 != 0. v1 = v0 && instruction1 != 0.
- freeze1 = v0 && (busy on any slot0 source || (slot0 mem-op && dmem_busy)).
- freeze2 = v0 && slot0 mem-op && dmem_busy.
- dependency_on_ins2 = v0 && !freeze1 && (any of):
  - !v1;
  - slot0 rd (nonzero) equals a slot1 source;
  - slot0 rd == slot1 rd (nonzero);
  - both slots are mem-ops;
  - slot0 is ctrl;
  - busy on any slot1 source;
  - slot1 is a mem-op and dmem_busy.
- freeze1 and dependency_on_ins2 are never both 1.

Issue register (1-cycle latency):
- issue0_valid <= v0 && !freeze1. issue0_instr <= instruction0 when that is 1, else 0.
- issue1_valid <= v0 && !freeze1 && !dependency_on_ins2. issue1_instr is likewise gated to 0.

FSM (status/counting only):
- EMPTY → ISSUE when v0 && !freeze1.
- EMPTY → HOLD when v0 && freeze1.
- ISSUE → HOLD on freeze1.
- HOLD → ISSUE when freeze1 drops.
- Any state → EMPTY when !v0.

Counters:
- issue_count += issue0_valid_next + issue1_valid_next each cycle.
- stall_count += 1 while freeze1.
- Both wrap modulo 2^CNT_W.

Boundary cases:
- Reset mid-stall: scoreboard and issue register clear immediately; freeze1 follows the new window on the first cycle after release.
- nothing_filled=1 with nonzero instruction0: no issue, no freeze.

Test Plan:
- Reset: drive n_rst=0 mid-stream → all outputs 0 asynchronously. Release with an empty window → freeze1=0, issue0_valid=0.
- Independent pair 0x002081B3 (add x3,x1,x2) / 0x0020A023 (sw x2,0(x1)) → dependency_on_ins2=0, freeze1=0. Next cycle: issue0/1_valid=1, issue_count=2.
- RAW in pair: add x3,x1,x2 / 0x00118233 (add x4,x3,x1) → dependency_on_ins2=1. Next cycle: issue0_valid=1, issue1_valid=0.
- Load-use, LOAD_LATENCY=2:
  - Window lw x5,0(x1) 0x0000A283 / addi x6,x5,1 0x00128313 → slide by 1.
  - Next window, head addi → freeze1=1 for exactly 2 cycles, stall_count=2, then addi issues.
- Two loads in the pair → dependency_on_ins2=1.
- dmem_busy=1 with lw at the head → freeze1=1, freeze2=1, no issue. Drop dmem_busy → issues next cycle.

Source files
------------

// File: rtl/dual_issue_scheduler.sv
// dual_issue_scheduler: picks 0, 1 or 2 head instructions from the window each cycle and registers them to execute.
//   clk, n_rst            : clock, asynchronous active-low reset
//   nothing_filled        : window empty, instruction0/1 invalid
//   instruction0/1        : window head / head+1 (0 = empty slot)
//   dmem_busy             : data memory cannot take a load/store this cycle
//   freeze1               : hold window, nothing issues
//   freeze2               : hold caused by dmem_busy (subset of freeze1)
//   dependency_on_ins2    : issue slot0 only, window slides by 1
//   issue0/1_valid, _instr: registered issued pair
//   issue_count           : instructions issued since reset
//   stall_count           : cycles with freeze1 asserted
module dual_issue_scheduler #(
   parameter int LOAD_LATENCY = 2,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             nothing_filled,
   input  logic [31:0]      instruction0,
   input  logic [31:0]      instruction1,
   input  logic             dmem_busy,
   output logic             freeze1,
   output logic             freeze2,
   output logic             dependency_on_ins2,
   output logic             issue0_valid,
   output logic [31:0]      issue0_instr,
   output logic             issue1_valid,
   output logic [31:0]      issue1_instr,
   output logic [CNT_W-1:0] issue_count,
   output logic [CNT_W-1:0] stall_count
);
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [2:0] LAT       = 3'(LOAD_LATENCY);

   typedef enum logic [1:0] {EMPTY, ISSUE, HOLD} state_t;

   function automatic logic uses_rs1(input logic [6:0] op);
      return op inside {OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR, OP_IMM, OP_OP};
   endfunction
   function automatic logic uses_rs2(input logic [6:0] op);
      return op inside {OP_STORE, OP_BRANCH, OP_OP};
   endfunction
   function automatic logic writes_rd(input logic [6:0] op);
      return op inside {OP_LOAD, OP_JALR, OP_JAL, OP_IMM, OP_OP};
   endfunction
   function automatic logic is_mem(input logic [6:0] op);
      return op inside {OP_LOAD, OP_STORE};
   endfunction
   function automatic logic is_ctrl(input logic [6:0] op);
      return op inside {OP_BRANCH, OP_JAL, OP_JALR};
   endfunction

   logic [6:0] op0, op1;
   logic [4:0] rd0, rs1_0, rs2_0, rd1, rs1_1, rs2_1;
   logic v0, v1, wr0, src_busy0, src_busy1, raw, waw, iss0, iss1, ld0, ld1;
   logic [31:0] busy;
   logic [31:0][2:0] cnt_q, cnt_d;
   state_t state_q, state_d;
   logic issue0_valid_q, issue1_valid_q;
   logic [31:0] issue0_instr_q, issue1_instr_q;
   logic [CNT_W-1:0] issue_count_q, stall_count_q;

   assign op0   = instruction0[6:0];
   assign rd0   = instruction0[11:7];
   assign rs1_0 = instruction0[19:15];
   assign rs2_0 = instruction0[24:20];
   assign op1   = instruction1[6:0];
   assign rd1   = instruction1[11:7];
   assign rs1_1 = instruction1[19:15];
   assign rs2_1 = instruction1[24:20];

   assign v0 = !nothing_filled && (instruction0 != '0);
   assign v1 = v0 && (instruction1 != '0);

   // x0 is never set in the scoreboard, so a source of x0 can never look busy
   always_comb
      for (int i = 0; i < 32; i++)
         busy[i] = cnt_q[i] != '0;

   assign src_busy0 = (uses_rs1(op0) && busy[rs1_0]) || (uses_rs2(op0) && busy[rs2_0]);
   assign src_busy1 = (uses_rs1(op1) && busy[rs1_1]) || (uses_rs2(op1) && busy[rs2_1]);
   assign wr0       = writes_rd(op0) && (rd0 != '0);
   assign raw       = wr0 && ((uses_rs1(op1) && rs1_1 == rd0) || (uses_rs2(op1) && rs2_1 == rd0));
   assign waw       = wr0 && writes_rd(op1) && (rd1 == rd0);

   assign freeze2            = v0 && is_mem(op0) && dmem_busy;
   assign freeze1            = v0 && (src_busy0 || freeze2);
   assign dependency_on_ins2 = v0 && !freeze1 && (!v1 || raw || waw || (is_mem(op0) && is_mem(op1)) ||
                               is_ctrl(op0) || src_busy1 || (is_mem(op1) && dmem_busy));

   assign iss0 = v0 && !freeze1;
   assign iss1 = iss0 && !dependency_on_ins2;
   assign ld0  = iss0 && (op0 == OP_LOAD) && (rd0 != '0);
   assign ld1  = iss1 && (op1 == OP_LOAD) && (rd1 != '0);

   // a fresh load destination overrides the decrement on that entry
   always_comb
      for (int i = 0; i < 32; i++) begin
         cnt_d[i] = busy[i] ? cnt_q[i] - 3'd1 : 3'd0;
         if ((ld0 && rd0 == 5'(i)) || (ld1 && rd1 == 5'(i)))
            cnt_d[i] = LAT;
      end

   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY:   state_d = !v0 ? EMPTY : freeze1 ? HOLD : ISSUE;
         ISSUE:   state_d = !v0 ? EMPTY : freeze1 ? HOLD : ISSUE;
         HOLD:    state_d = !v0 ? EMPTY : freeze1 ? HOLD : ISSUE;
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) begin
         cnt_q          <= '0;
         state_q        <= EMPTY;
         issue0_valid_q <= 1'b0;
         issue1_valid_q <= 1'b0;
         issue0_instr_q <= '0;
         issue1_instr_q <= '0;
         issue_count_q  <= '0;
         stall_count_q  <= '0;
      end else begin
         cnt_q          <= cnt_d;
         state_q        <= state_d;
         issue0_valid_q <= iss0;
         issue1_valid_q <= iss1;
         issue0_instr_q <= iss0 ? instruction0 : '0;
         issue1_instr_q <= iss1 ? instruction1 : '0;
         issue_count_q  <= issue_count_q + CNT_W'(iss0) + CNT_W'(iss1);
         stall_count_q  <= stall_count_q + CNT_W'(freeze1);
      end

   assign issue0_valid = issue0_valid_q;
   assign issue1_valid = issue1_valid_q;
   assign issue0_instr = issue0_instr_q;
   assign issue1_instr = issue1_instr_q;
   assign issue_count  = issue_count_q;
   assign stall_count  = stall_count_q;
endmodule

// File: tb/tb_dual_issue_scheduler.sv
// tb_dual_issue_scheduler: directed vectors for dual_issue_scheduler with hand-computed expectations.
module tb_dual_issue_scheduler;
   localparam logic [31:0] ADD3  = 32'h002081B3; // add x3,x1,x2
   localparam logic [31:0] SW21  = 32'h0020A023; // sw x2,0(x1)
   localparam logic [31:0] ADD4  = 32'h00118233; // add x4,x3,x1
   localparam logic [31:0] LW5   = 32'h0000A283; // lw x5,0(x1)
   localparam logic [31:0] ADDI6 = 32'h00128313; // addi x6,x5,1
   localparam logic [31:0] LW7   = 32'h00012383; // lw x7,0(x2)

   logic clk = 1'b0;
   logic n_rst = 1'b0;
   logic nothing_filled = 1'b1;
   logic [31:0] instruction0 = '0;
   logic [31:0] instruction1 = '0;
   logic dmem_busy = 1'b0;
   logic freeze1, freeze2, dependency_on_ins2, issue0_valid, issue1_valid;
   logic [31:0] issue0_instr, issue1_instr, issue_count, stall_count;
   int n_checks = 0;
   int n_fails = 0;

   always #5 clk = ~clk;

   dual_issue_scheduler #(.LOAD_LATENCY(2), .CNT_W(32)) dut (
      .clk(clk), .n_rst(n_rst), .nothing_filled(nothing_filled),
      .instruction0(instruction0), .instruction1(instruction1), .dmem_busy(dmem_busy),
      .freeze1(freeze1), .freeze2(freeze2), .dependency_on_ins2(dependency_on_ins2),
      .issue0_valid(issue0_valid), .issue0_instr(issue0_instr),
      .issue1_valid(issue1_valid), .issue1_instr(issue1_instr),
      .issue_count(issue_count), .stall_count(stall_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic nf, input logic [31:0] i0, input logic [31:0] i1, input logic db);
      @(negedge clk);
      nothing_filled = nf;
      instruction0 = i0;
      instruction1 = i1;
      dmem_busy = db;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1;
      check("rst_f1", 32'(freeze1), 0);
      check("rst_v0", 32'(issue0_valid), 0);
      check("rst_ic", issue_count, 0);
      check("rst_sc", stall_count, 0);
      drive(1'b1, '0, '0, 1'b0);
      n_rst = 1'b1;
      tick();
      check("empty_f1", 32'(freeze1), 0);
      check("empty_v0", 32'(issue0_valid), 0);

      drive(1'b0, ADD3, SW21, 1'b0);
      check("indep_dep", 32'(dependency_on_ins2), 0);
      check("indep_f1", 32'(freeze1), 0);
      tick();
      check("indep_v0", 32'(issue0_valid), 1);
      check("indep_v1", 32'(issue1_valid), 1);
      check("indep_i0", issue0_instr, ADD3);
      check("indep_i1", issue1_instr, SW21);
      check("indep_ic", issue_count, 2);

      drive(1'b0, ADD3, ADD4, 1'b0);
      check("raw_dep", 32'(dependency_on_ins2), 1);
      check("raw_f1", 32'(freeze1), 0);
      tick();
      check("raw_v0", 32'(issue0_valid), 1);
      check("raw_v1", 32'(issue1_valid), 0);
      check("raw_i1", issue1_instr, 0);
      check("raw_ic", issue_count, 3);

      drive(1'b0, LW5, ADDI6, 1'b0);
      check("lu_dep", 32'(dependency_on_ins2), 1);
      tick();
      check("lu_v0", 32'(issue0_valid), 1);
      check("lu_ic", issue_count, 4);
      drive(1'b0, ADDI6, '0, 1'b0);
      check("lu_f1a", 32'(freeze1), 1);
      check("lu_f2a", 32'(freeze2), 0);
      check("lu_depa", 32'(dependency_on_ins2), 0);
      tick();
      check("lu_stall_v0", 32'(issue0_valid), 0);
      check("lu_sc1", stall_count, 1);
      check("lu_f1b", 32'(freeze1), 1);
      tick();
      check("lu_sc2", stall_count, 2);
      check("lu_f1c", 32'(freeze1), 0);
      check("lu_depc", 32'(dependency_on_ins2), 1);
      tick();
      check("lu_v0d", 32'(issue0_valid), 1);
      check("lu_i0d", issue0_instr, ADDI6);
      check("lu_icd", issue_count, 5);
      check("lu_scd", stall_count, 2);

      drive(1'b0, LW5, LW7, 1'b0);
      check("ll_dep", 32'(dependency_on_ins2), 1);
      check("ll_f1", 32'(freeze1), 0);
      tick();
      check("ll_v1", 32'(issue1_valid), 0);
      check("ll_ic", issue_count, 6);

      drive(1'b0, LW7, '0, 1'b1);
      check("db_f1", 32'(freeze1), 1);
      check("db_f2", 32'(freeze2), 1);
      check("db_dep", 32'(dependency_on_ins2), 0);
      tick();
      check("db_v0", 32'(issue0_valid), 0);
      check("db_sc", stall_count, 3);
      drive(1'b0, LW7, '0, 1'b0);
      check("db_drop_f1", 32'(freeze1), 0);
      check("db_drop_f2", 32'(freeze2), 0);
      tick();
      check("db_drop_v0", 32'(issue0_valid), 1);
      check("db_drop_i0", issue0_instr, LW7);
      check("db_drop_ic", issue_count, 7);

      drive(1'b0, ADD3, SW21, 1'b1);
      check("db1_dep", 32'(dependency_on_ins2), 1);
      check("db1_f1", 32'(freeze1), 0);
      tick();
      check("db1_v1", 32'(issue1_valid), 0);
      check("db1_ic", issue_count, 8);

      drive(1'b1, ADD3, SW21, 1'b0);
      check("nf_f1", 32'(freeze1), 0);
      check("nf_dep", 32'(dependency_on_ins2), 0);
      tick();
      check("nf_v0", 32'(issue0_valid), 0);
      check("nf_ic", issue_count, 8);

      drive(1'b0, LW5, '0, 1'b0);
      tick();
      check("rs_ic", issue_count, 9);
      drive(1'b0, ADDI6, '0, 1'b0);
      check("rs_f1", 32'(freeze1), 1);
      tick();
      check("rs_sc", stall_count, 4);
      #2;
      n_rst = 1'b0;
      #1;
      check("rs_mid_f1", 32'(freeze1), 0);
      check("rs_mid_v0", 32'(issue0_valid), 0);
      check("rs_mid_i0", issue0_instr, 0);
      check("rs_mid_ic", issue_count, 0);
      check("rs_mid_sc", stall_count, 0);
      drive(1'b0, ADDI6, '0, 1'b0);
      n_rst = 1'b1;
      check("rs_rel_f1", 32'(freeze1), 0);
      check("rs_rel_dep", 32'(dependency_on_ins2), 1);
      tick();
      check("rs_rel_v0", 32'(issue0_valid), 1);
      check("rs_rel_ic", issue_count, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
